// File: rtl/irq_timer_pkg.sv
// irq_timer_pkg: shared definitions for the irq_timer peripheral.
//   - block base address on the picorv32 native bus
//   - register index enum (addr[3:2]) and CTRL/STATUS bit positions
//   - bus FSM state enum
//   - apply_wstrb(): byte-lane merge of write data into a 32-bit register image
package irq_timer_pkg;

  localparam logic [31:0] IRQ_TIMER_BASE = 32'h8000_0010;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } reg_idx_e;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_ONESHOT_BIT  = 2;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int STATUS_MATCH_BIT  = 0;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock down to a one-cycle tick.
//   clk, reset  : clock, asynchronous active-high reset
//   prescale    : tick period minus one
//   en          : counter runs while high, holds at 0 while low
//   clear       : forces the counter back to 0 (CTRL write)
//   tick        : high for one cycle every prescale+1 enabled cycles
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      en,
  input  logic                      clear,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
    if (clear || !en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/irq_timer.sv
// irq_timer: memory-mapped timer/compare peripheral for the picorv32 bus.
//   clk, reset : clock, asynchronous active-high reset
//   sel        : slave select, held by the master until ready
//   addr       : byte offset in the block, [3:2] selects the register
//   wstrb      : byte write strobes, 0 = read
//   wdata      : write data
//   rdata      : registered read data
//   ready      : one-cycle transfer-complete pulse
//   irq        : CPU irq vector, bit 0 = MATCH & IRQ_EN
// Registers: 0 CTRL {PRESCALE[15:8], ONESHOT, IRQ_EN, EN}, 1 COUNT,
//            2 COMPARE, 3 STATUS {MATCH (write 1 to clear)}.
// Handshake: a transfer is accepted on the edge where sel=1 in IDLE; that
// edge commits the write or loads rdata and raises ready for one cycle. The
// FSM stays in ACK until sel drops, so a select held past its ready never
// starts a second transfer.
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] irq
);

  bus_state_e                state_q, state_d;
  logic                      ready_q, ready_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      en_q, en_d;
  logic                      irq_en_q, irq_en_d;
  logic                      oneshot_q, oneshot_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [COUNT_WIDTH-1:0]    compare_q, compare_d;
  logic                      match_q, match_d;

  logic [3:0]  offset;
  logic [1:0]  unused_offset_lsb;
  reg_idx_e    reg_idx;
  logic        accept, wr_en, rd_en;
  logic        ctrl_wr, count_wr, compare_wr, status_wr;
  logic        tick, match_set, match_clr;
  logic [31:0] ctrl_rd, count_merged, compare_merged;

  // Offset relative to the block base; only the word index is decoded.
  assign offset            = addr - IRQ_TIMER_BASE[3:0];
  assign unused_offset_lsb = offset[1:0];
  assign reg_idx           = reg_idx_e'(offset[3:2]);

  assign accept     = (state_q == BUS_IDLE) && sel;
  assign wr_en      = accept && (wstrb != 4'b0000);
  assign rd_en      = accept && (wstrb == 4'b0000);
  assign ctrl_wr    = wr_en && (reg_idx == REG_CTRL);
  assign count_wr   = wr_en && (reg_idx == REG_COUNT);
  assign compare_wr = wr_en && (reg_idx == REG_COMPARE);
  assign status_wr  = wr_en && (reg_idx == REG_STATUS);

  assign count_merged   = apply_wstrb(32'(count_q), wdata, wstrb);
  assign compare_merged = apply_wstrb(32'(compare_q), wdata, wstrb);

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .prescale (prescale_q),
    .en       (en_q),
    .clear    (ctrl_wr),
    .tick     (tick)
  );

  // Bus FSM
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (sel) begin
          state_d = BUS_ACK;
          ready_d = 1'b1;
        end
      end
      BUS_ACK: begin
        if (!sel) state_d = BUS_IDLE;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    ctrl_rd                                       = '0;
    ctrl_rd[CTRL_EN_BIT]                          = en_q;
    ctrl_rd[CTRL_IRQ_EN_BIT]                      = irq_en_q;
    ctrl_rd[CTRL_ONESHOT_BIT]                     = oneshot_q;
    ctrl_rd[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH]  = prescale_q;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (reg_idx)
        REG_CTRL:    rdata_d = ctrl_rd;
        REG_COUNT:   rdata_d = 32'(count_q);
        REG_COMPARE: rdata_d = 32'(compare_q);
        REG_STATUS:  rdata_d = 32'(match_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  // Timer update: the tick result is computed first so that bus writes,
  // applied afterwards, override it (COUNT write beats a tick, CTRL write
  // beats the one-shot EN clear).
  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    oneshot_d  = oneshot_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_set  = 1'b0;

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        count_d   = '0;
        if (oneshot_q) en_d = 1'b0;
      end else begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end

    if (ctrl_wr) begin
      if (wstrb[0]) begin
        en_d      = wdata[CTRL_EN_BIT];
        irq_en_d  = wdata[CTRL_IRQ_EN_BIT];
        oneshot_d = wdata[CTRL_ONESHOT_BIT];
      end
      if (wstrb[1]) prescale_d = wdata[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
    end
    if (count_wr)   count_d   = count_merged[COUNT_WIDTH-1:0];
    if (compare_wr) compare_d = compare_merged[COUNT_WIDTH-1:0];

    // A new match in the same cycle as a clear keeps MATCH set.
    match_clr = status_wr && wstrb[0] && wdata[STATUS_MATCH_BIT];
    match_d   = (match_q && !match_clr) || match_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BUS_IDLE;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      oneshot_q  <= 1'b0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= '1;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      oneshot_q  <= oneshot_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign irq   = {31'b0, match_q && irq_en_q};

endmodule

// File: tb/tb_irq_timer.sv
// Directed testbench for irq_timer: one task per feature, each with its own
// inline comparisons against hand-computed values.
module tb_irq_timer;

  localparam logic [3:0] A_CTRL    = 4'h0;
  localparam logic [3:0] A_COUNT   = 4'h4;
  localparam logic [3:0] A_COMPARE = 4'h8;
  localparam logic [3:0] A_STATUS  = 4'hC;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [3:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] irq;

  int checks   = 0;
  int failures = 0;

  irq_timer dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .addr  (addr),
    .wstrb (wstrb),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .irq   (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // driver tasks: each transfer ends with one idle edge so the next starts clean
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit done;
    done = 1'b0;
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wstrb = s;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      if (ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL write_ready addr=%h: ready=0, required 1 within 8 cycles", a);
    end
    sel = 1'b0; wstrb = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bit done;
    done = 1'b0;
    d = 32'hDEAD_BEEF;
    @(negedge clk);
    sel = 1'b1; addr = a; wstrb = 4'b0000;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        done = 1'b1;
        d = rdata;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL read_ready addr=%h: ready=0, required 1 within 8 cycles", a);
    end
    sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic stop_timer();
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(A_COUNT, 32'h0, 4'hF);
    bus_write(A_STATUS, 32'h1, 4'h1);
  endtask

  // tests
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=00000000", rdata); end
    checks++; if (irq !== 32'h0) begin failures++; $display("FAIL rst_irq got=%h exp=00000000", irq); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_COMPARE, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_compare got=%h exp=ffffffff", v); end
    bus_read(A_CTRL, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=00000000", v); end
    bus_read(A_COUNT, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_count got=%h exp=00000000", v); end
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_status got=%h exp=00000000", v); end
  endtask

  task automatic test_handshake();
    logic [31:0] v;
    // select held five edges: ready only at the first
    @(negedge clk);
    sel = 1'b1; addr = A_CTRL; wstrb = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== (i == 0)) begin
        failures++;
        $display("FAIL hold_ready edge=%0d got=%b exp=%b", i, ready, (i == 0));
      end
    end
    sel = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ready_no_sel got=%b exp=0", ready); end
    // byte lanes
    bus_write(A_COUNT, 32'h0000_AB00, 4'b0010);
    bus_read(A_COUNT, v);
    checks++; if (v !== 32'h0000_AB00) begin failures++; $display("FAIL count_lane1 got=%h exp=0000ab00", v); end
    bus_write(A_COUNT, 32'h1234_5678, 4'b1111);
    bus_write(A_COUNT, 32'h0000_CD00, 4'b0010);
    bus_read(A_COUNT, v);
    checks++; if (v !== 32'h1234_CD78) begin failures++; $display("FAIL count_merge got=%h exp=1234cd78", v); end
    bus_write(A_CTRL, 32'hFFFF_FFF8, 4'b1111);
    bus_read(A_CTRL, v);
    checks++; if (v !== 32'h0000_FF00) begin failures++; $display("FAIL ctrl_mask got=%h exp=0000ff00", v); end
    bus_write(A_CTRL, 32'h0000_0503, 4'b0010);
    bus_read(A_CTRL, v);
    checks++; if (v !== 32'h0000_0500) begin failures++; $display("FAIL ctrl_lane1 got=%h exp=00000500", v); end
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(A_COUNT, 32'h0, 4'hF);
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    bus_write(A_COMPARE, 32'd4, 4'hF);
    bus_write(A_CTRL, 32'h0000_0203, 4'hF);  // commit edge E0, return after E1
    repeat (13) @(posedge clk);              // E14
    #1;
    checks++; if (irq !== 32'h0) begin failures++; $display("FAIL per_pre got=%h exp=00000000", irq); end
    @(posedge clk); #1;                      // E15
    checks++; if (irq !== 32'h1) begin failures++; $display("FAIL per_first got=%h exp=00000001", irq); end
    // inline STATUS clear committing at E16
    @(negedge clk);
    sel = 1'b1; addr = A_STATUS; wdata = 32'h1; wstrb = 4'b0001;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL per_clr_ready got=%b exp=1", ready); end
    checks++; if (irq !== 32'h0) begin failures++; $display("FAIL per_clr_irq got=%h exp=00000000", irq); end
    sel = 1'b0; wstrb = 4'b0000;
    repeat (13) @(posedge clk);              // E29
    #1;
    checks++; if (irq !== 32'h0) begin failures++; $display("FAIL per_gap got=%h exp=00000000", irq); end
    @(posedge clk); #1;                      // E30
    checks++; if (irq !== 32'h1) begin failures++; $display("FAIL per_second got=%h exp=00000001", irq); end
    bus_read(A_COUNT, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL per_reload got=%h exp=00000000", v); end
    stop_timer();
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    bus_write(A_COMPARE, 32'd2, 4'hF);
    bus_write(A_CTRL, 32'h0000_0007, 4'hF);  // E0, return after E1
    @(posedge clk); #1;                      // E2
    checks++; if (irq !== 32'h0) begin failures++; $display("FAIL os_pre got=%h exp=00000000", irq); end
    @(posedge clk); #1;                      // E3
    checks++; if (irq !== 32'h1) begin failures++; $display("FAIL os_match got=%h exp=00000001", irq); end
    repeat (20) @(posedge clk);
    bus_read(A_CTRL, v);
    checks++; if (v !== 32'h0000_0006) begin failures++; $display("FAIL os_ctrl got=%h exp=00000006", v); end
    bus_read(A_COUNT, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL os_count got=%h exp=00000000", v); end
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL os_status got=%h exp=00000001", v); end
    bus_write(A_STATUS, 32'h1, 4'h1);
    checks++; if (irq !== 32'h0) begin failures++; $display("FAIL os_clear got=%h exp=00000000", irq); end
    stop_timer();
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    // STATUS clear on the same edge as a match: matches at E3, E6, E9
    bus_write(A_COMPARE, 32'd2, 4'hF);
    bus_write(A_CTRL, 32'h0000_0003, 4'hF);  // E0
    repeat (4) @(posedge clk);               // E5
    bus_write(A_STATUS, 32'h1, 4'h1);        // commits at E6, returns after E7
    checks++; if (irq !== 32'h1) begin failures++; $display("FAIL col_setwins got=%h exp=00000001", irq); end
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL col_status got=%h exp=00000001", v); end
    stop_timer();
    // COUNT write on a tick edge: PRESCALE=3, ticks at E4, E8
    bus_write(A_COMPARE, 32'h100, 4'hF);
    bus_write(A_CTRL, 32'h0000_0301, 4'hF);  // E0
    repeat (2) @(posedge clk);               // E3
    bus_write(A_COUNT, 32'h50, 4'hF);        // commits at E4
    bus_read(A_COUNT, v);                    // commits at E6
    checks++; if (v !== 32'h50) begin failures++; $display("FAIL col_countwins got=%h exp=00000050", v); end
    stop_timer();
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    bus_write(A_COUNT, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_COMPARE, 32'h1, 4'hF);
    bus_write(A_CTRL, 32'h0000_0003, 4'hF);  // E0: count FFFFFFFF@E1, 0@E2, 1@E3, match@E4
    bus_read(A_COUNT, v);                    // commits at E2
    checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffffffff", v); end
    checks++; if (irq !== 32'h0) begin failures++; $display("FAIL wrap_noflag got=%h exp=00000000", irq); end
    bus_read(A_COUNT, v);                    // commits at E4
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL wrap_one got=%h exp=00000001", v); end
    checks++; if (irq !== 32'h1) begin failures++; $display("FAIL wrap_match got=%h exp=00000001", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    @(negedge clk);
    sel = 1'b1; addr = A_CTRL; wstrb = 4'b0000;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_ready_pre got=%b exp=1", ready); end
    #1 reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", ready); end
    checks++; if (irq !== 32'h0) begin failures++; $display("FAIL mid_irq got=%h exp=00000000", irq); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mid_rdata got=%h exp=00000000", rdata); end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_COMPARE, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mid_compare got=%h exp=ffffffff", v); end
    bus_read(A_COUNT, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL mid_count got=%h exp=00000000", v); end
    bus_read(A_CTRL, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL mid_ctrl got=%h exp=00000000", v); end
  endtask

  initial begin
    sel   = 1'b0;
    addr  = 4'h0;
    wstrb = 4'h0;
    wdata = 32'h0;
    reset = 1'b1;
    test_reset();
    test_handshake();
    test_periodic();
    test_oneshot();
    test_collisions();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
